// File: rtl/anabellek_blok_okuyucu_pkg.sv
// Shared memory definitions for the block reader: widths, counter sizes and FSM states.
package anabellek_blok_okuyucu_pkg;

  localparam int unsigned ADRES_BIT        = 32;
  localparam int unsigned VERI_BIT         = 32;
  localparam int unsigned BLOK_KELIME      = 4;
  localparam int unsigned BLOK_BIT         = VERI_BIT * BLOK_KELIME;
  localparam int unsigned OFSET_BIT        = $clog2(BLOK_BIT / 8);
  localparam int unsigned KELIME_OFSET_BIT = $clog2(VERI_BIT / 8);
  localparam int unsigned SAYAC_BIT        = $clog2(BLOK_KELIME) + 1;

  localparam logic [SAYAC_BIT-1:0] SAYAC_SON = SAYAC_BIT'(BLOK_KELIME);
  localparam logic [SAYAC_BIT-1:0] SAYAC_BIR = SAYAC_BIT'(1);

  typedef enum logic [1:0] {
    StBosta = 2'd0,
    StIstek = 2'd1,
    StTamam = 2'd2
  } durum_e;

  // Clears the byte offset inside a block so every beat stays within it.
  function automatic logic [ADRES_BIT-1:0] blok_hizala(input logic [ADRES_BIT-1:0] adres);
    return adres & ~ADRES_BIT'((1 << OFSET_BIT) - 1);
  endfunction

endpackage

// File: rtl/anabellek_blok_okuyucu_if.sv
// Cache-port and memory-bus signals of the block reader, grouped with master/slave views.
interface anabellek_blok_okuyucu_if;
  import anabellek_blok_okuyucu_pkg::*;

  logic [ADRES_BIT-1:0] b_okuma_istek_adres_i;
  logic                 b_okuma_istek_gecerli_i;
  logic [BLOK_BIT-1:0]  b_okuma_veri_blok_o;
  logic                 b_okuma_istek_hazir_o;
  logic [ADRES_BIT-1:0] v_okuma_istek_adres_i;
  logic                 v_okuma_istek_gecerli_i;
  logic [BLOK_BIT-1:0]  v_okuma_veri_blok_o;
  logic                 v_okuma_istek_hazir_o;
  logic [ADRES_BIT-1:0] bellek_istek_adres_o;
  logic                 bellek_istek_gecerli_o;
  logic                 bellek_istek_hazir_i;
  logic [VERI_BIT-1:0]  bellek_yanit_veri_i;
  logic                 bellek_yanit_gecerli_i;
  logic                 mesgul_o;

  modport slave (
    input  b_okuma_istek_adres_i, b_okuma_istek_gecerli_i,
    output b_okuma_veri_blok_o, b_okuma_istek_hazir_o,
    input  v_okuma_istek_adres_i, v_okuma_istek_gecerli_i,
    output v_okuma_veri_blok_o, v_okuma_istek_hazir_o,
    output bellek_istek_adres_o, bellek_istek_gecerli_o,
    input  bellek_istek_hazir_i, bellek_yanit_veri_i, bellek_yanit_gecerli_i,
    output mesgul_o
  );

  modport master (
    output b_okuma_istek_adres_i, b_okuma_istek_gecerli_i,
    input  b_okuma_veri_blok_o, b_okuma_istek_hazir_o,
    output v_okuma_istek_adres_i, v_okuma_istek_gecerli_i,
    input  v_okuma_veri_blok_o, v_okuma_istek_hazir_o,
    input  bellek_istek_adres_o, bellek_istek_gecerli_o,
    output bellek_istek_hazir_i, bellek_yanit_veri_i, bellek_yanit_gecerli_i,
    input  mesgul_o
  );

endinterface

// File: rtl/anabellek_hakem.sv
// Two-port round-robin arbiter: bit 0 is port B, bit 1 is port V; one-hot grant out.
module anabellek_hakem (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       etkin_i,
  input  logic [1:0] istek_i,
  output logic [1:0] izin_o
);

  // 0: B wins the next tie, 1: V wins the next tie.
  logic oncelik_d, oncelik_q;

  always_comb begin
    izin_o    = 2'b00;
    oncelik_d = oncelik_q;
    if (etkin_i) begin
      unique case (istek_i)
        2'b01: izin_o = 2'b01;
        2'b10: izin_o = 2'b10;
        2'b11: begin
          izin_o    = oncelik_q ? 2'b10 : 2'b01;
          oncelik_d = ~oncelik_q;
        end
        default: izin_o = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      oncelik_q <= 1'b0;
    end else begin
      oncelik_q <= oncelik_d;
    end
  end

endmodule

// File: rtl/anabellek_blok_okuyucu.sv
// Main-memory block reader: arbitrates two cache ports, issues word reads on a pipelined
// bus, assembles the in-order responses and returns the block with a one-cycle ready pulse.
module anabellek_blok_okuyucu
  import anabellek_blok_okuyucu_pkg::*;
(
  input logic                    clk_i,
  input logic                    rst_i,
  anabellek_blok_okuyucu_if.slave bus_io
);

  durum_e               durum_d, durum_q;
  logic                 sahip_d, sahip_q;  // 0: port B, 1: port V
  logic [ADRES_BIT-1:0] taban_d, taban_q;
  logic [SAYAC_BIT-1:0] verilen_d, verilen_q;
  logic [SAYAC_BIT-1:0] alinan_d, alinan_q;
  logic [BLOK_BIT-1:0]  tampon_d, tampon_q;
  logic                 gecerli_d, gecerli_q;
  logic [ADRES_BIT-1:0] adres_d, adres_q;
  logic [BLOK_BIT-1:0]  b_blok_d, b_blok_q;
  logic [BLOK_BIT-1:0]  v_blok_d, v_blok_q;
  logic                 b_hazir_d, b_hazir_q;
  logic                 v_hazir_d, v_hazir_q;

  logic [1:0] istek;
  logic [1:0] izin;

  assign istek = {bus_io.v_okuma_istek_gecerli_i, bus_io.b_okuma_istek_gecerli_i};

  anabellek_hakem u_hakem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .etkin_i (durum_q == StBosta),
    .istek_i (istek),
    .izin_o  (izin)
  );

  always_comb begin
    durum_d   = durum_q;
    sahip_d   = sahip_q;
    taban_d   = taban_q;
    verilen_d = verilen_q;
    alinan_d  = alinan_q;
    tampon_d  = tampon_q;
    gecerli_d = gecerli_q;
    adres_d   = adres_q;
    b_blok_d  = b_blok_q;
    v_blok_d  = v_blok_q;
    b_hazir_d = 1'b0;
    v_hazir_d = 1'b0;

    unique case (durum_q)
      StBosta: begin
        if (|izin) begin
          sahip_d   = izin[1];
          taban_d   = blok_hizala(izin[1] ? bus_io.v_okuma_istek_adres_i
                                          : bus_io.b_okuma_istek_adres_i);
          verilen_d = '0;
          alinan_d  = '0;
          tampon_d  = '0;
          gecerli_d = 1'b1;
          adres_d   = taban_d;
          durum_d   = StIstek;
        end
      end
      StIstek: begin
        if (gecerli_q && bus_io.bellek_istek_hazir_i) begin
          verilen_d = verilen_q + SAYAC_BIR;
          gecerli_d = (verilen_d < SAYAC_SON);
          adres_d   = taban_q + (ADRES_BIT'(verilen_d) << KELIME_OFSET_BIT);
        end
        if (bus_io.bellek_yanit_gecerli_i) begin
          for (int unsigned k = 0; k < BLOK_KELIME; k++) begin
            if (alinan_q == SAYAC_BIT'(k)) begin
              tampon_d[k*VERI_BIT +: VERI_BIT] = bus_io.bellek_yanit_veri_i;
            end
          end
          alinan_d = alinan_q + SAYAC_BIR;
          // The final word is taken straight from tampon_d so hazir lands one cycle later.
          if (alinan_d == SAYAC_SON) begin
            durum_d   = StTamam;
            gecerli_d = 1'b0;
            if (sahip_q) begin
              v_blok_d  = tampon_d;
              v_hazir_d = 1'b1;
            end else begin
              b_blok_d  = tampon_d;
              b_hazir_d = 1'b1;
            end
          end
        end
      end
      StTamam: durum_d = StBosta;
      default: durum_d = StBosta;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q   <= StBosta;
      sahip_q   <= 1'b0;
      taban_q   <= '0;
      verilen_q <= '0;
      alinan_q  <= '0;
      tampon_q  <= '0;
      gecerli_q <= 1'b0;
      adres_q   <= '0;
      b_blok_q  <= '0;
      v_blok_q  <= '0;
      b_hazir_q <= 1'b0;
      v_hazir_q <= 1'b0;
    end else begin
      durum_q   <= durum_d;
      sahip_q   <= sahip_d;
      taban_q   <= taban_d;
      verilen_q <= verilen_d;
      alinan_q  <= alinan_d;
      tampon_q  <= tampon_d;
      gecerli_q <= gecerli_d;
      adres_q   <= adres_d;
      b_blok_q  <= b_blok_d;
      v_blok_q  <= v_blok_d;
      b_hazir_q <= b_hazir_d;
      v_hazir_q <= v_hazir_d;
    end
  end

  assign bus_io.b_okuma_veri_blok_o    = b_blok_q;
  assign bus_io.b_okuma_istek_hazir_o  = b_hazir_q;
  assign bus_io.v_okuma_veri_blok_o    = v_blok_q;
  assign bus_io.v_okuma_istek_hazir_o  = v_hazir_q;
  assign bus_io.bellek_istek_adres_o   = adres_q;
  assign bus_io.bellek_istek_gecerli_o = gecerli_q;
  assign bus_io.mesgul_o               = (durum_q != StBosta);

endmodule

// File: tb/tb_anabellek_blok_okuyucu.sv
// Bench for the block reader: directed scenarios plus randomized traffic against a
// transaction-level model of memory contents and round-robin ordering.
module tb_anabellek_blok_okuyucu;
  import anabellek_blok_okuyucu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  anabellek_blok_okuyucu_if bus ();

  anabellek_blok_okuyucu dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  int vektor = 0;
  int hata   = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic kontrol(input string etiket, input logic [BLOK_BIT-1:0] gozlenen,
                         input logic [BLOK_BIT-1:0] beklenen);
    vektor++;
    assert (gozlenen === beklenen) else begin
      hata++;
      $error("FAIL %s: gozlenen=%0h beklenen=%0h", etiket, gozlenen, beklenen);
    end
  endtask

  // Memory contents: a few pinned words, everything else a seeded hash of the address.
  logic [31:0] bellek_ozel [logic [31:0]];
  int unsigned tohum;

  function automatic logic [31:0] bellek_oku(input logic [31:0] a);
    if (bellek_ozel.exists(a)) return bellek_ozel[a];
    return (a * 32'h9E37_79B1) ^ tohum;
  endfunction

  function automatic logic [BLOK_BIT-1:0] beklenen_blok(input logic [31:0] adres);
    logic [BLOK_BIT-1:0] r;
    logic [31:0] taban;
    taban = adres & ~32'(BLOK_BIT / 8 - 1);
    for (int k = 0; k < BLOK_KELIME; k++) r[k*VERI_BIT +: VERI_BIT] = bellek_oku(taban + 32'(4 * k));
    return r;
  endfunction

  // Memory responder knobs and state.
  typedef struct {
    logic [31:0] adres;
    int          vade;
  } bekleyen_t;
  bekleyen_t   bekleyen[$];
  int          gecikme = 1, hazir_olas = 100, yanit_olas = 100;
  int          stall_vurus = -1, stall_kalan = 0, bosluk_sonra = -1, bosluk_kalan = 0;
  int          vurus = 0, yanit_sayac = 0;
  logic [31:0] exp_taban = '0;

  initial begin : bellek_modeli
    bus.bellek_istek_hazir_i   = 1'b0;
    bus.bellek_yanit_gecerli_i = 1'b0;
    bus.bellek_yanit_veri_i    = '0;
    forever begin
      @(negedge clk);
      bus.bellek_yanit_gecerli_i = 1'b0;
      if (bekleyen.size() > 0 && bekleyen[0].vade <= cyc) begin
        if (yanit_sayac == bosluk_sonra && bosluk_kalan > 0) bosluk_kalan--;
        else if ($urandom_range(0, 99) < yanit_olas) begin
          bus.bellek_yanit_gecerli_i = 1'b1;
          bus.bellek_yanit_veri_i    = bellek_oku(bekleyen[0].adres);
          void'(bekleyen.pop_front());
          yanit_sayac++;
        end
      end
      if (bus.bellek_istek_gecerli_o && vurus == stall_vurus && stall_kalan > 0) begin
        bus.bellek_istek_hazir_i = 1'b0;
        stall_kalan--;
      end else begin
        bus.bellek_istek_hazir_i = ($urandom_range(0, 99) < hazir_olas);
      end
      if (bus.bellek_istek_gecerli_o) begin
        kontrol("vurus_adresi", bus.bellek_istek_adres_o, exp_taban + 32'(4 * vurus));
        if (bus.bellek_istek_hazir_i) begin
          kontrol("vurus_siniri", vurus < BLOK_KELIME, 1);
          bekleyen.push_back('{bus.bellek_istek_adres_o, cyc + gecikme});
          vurus++;
        end
      end
    end
  end

  // Transaction-level model: round-robin pointer moves only on a tie.
  bit              oncelik_v = 1'b0;
  logic [BLOK_BIT-1:0] son_b = '0, son_v = '0;

  function automatic bit kazanan(input bit b, input bit v);
    bit w;
    if (b && v) begin
      w = oncelik_v;
      oncelik_v = !oncelik_v;
    end else begin
      w = v;
    end
    return w;
  endfunction

  task automatic yeni_islem(input logic [31:0] adres);
    exp_taban   = adres & ~32'(BLOK_BIT / 8 - 1);
    vurus       = 0;
    yanit_sayac = 0;
  endtask

  task automatic hazir_bekle(input bit sahip_v, input logic [31:0] adres, output int sure);
    int basla;
    bit goruldu;
    logic [BLOK_BIT-1:0] beklenen;
    basla = cyc;
    goruldu = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.b_okuma_istek_hazir_o || bus.v_okuma_istek_hazir_o) begin
        goruldu = 1'b1;
        break;
      end
    end
    sure = cyc - basla;
    kontrol("hazir_zaman_asimi", goruldu, 1);
    if (goruldu) begin
      beklenen = beklenen_blok(adres);
      kontrol("hazir_portu", {bus.b_okuma_istek_hazir_o, bus.v_okuma_istek_hazir_o},
              sahip_v ? 2'b01 : 2'b10);
      if (sahip_v) begin
        kontrol("v_blok", bus.v_okuma_veri_blok_o, beklenen);
        kontrol("b_blok_tut", bus.b_okuma_veri_blok_o, son_b);
        son_v = beklenen;
        bus.v_okuma_istek_gecerli_i = 1'b0;
      end else begin
        kontrol("b_blok", bus.b_okuma_veri_blok_o, beklenen);
        kontrol("v_blok_tut", bus.v_okuma_veri_blok_o, son_v);
        son_b = beklenen;
        bus.b_okuma_istek_gecerli_i = 1'b0;
      end
      @(negedge clk);
      kontrol("hazir_darbe", {bus.b_okuma_istek_hazir_o, bus.v_okuma_istek_hazir_o}, 2'b00);
      kontrol("mesgul_bosta", bus.mesgul_o, 0);
    end
  endtask

  // Raises the requested ports together and serves them in model order.
  task automatic calistir(input bit b_ist, input bit v_ist, input logic [31:0] b_adr,
                          input logic [31:0] v_adr, output int sure);
    bit w;
    bus.b_okuma_istek_adres_i   = b_adr;
    bus.v_okuma_istek_adres_i   = v_adr;
    bus.b_okuma_istek_gecerli_i = b_ist;
    bus.v_okuma_istek_gecerli_i = v_ist;
    sure = 0;
    for (int k = 0; k < 2; k++) begin
      if (bus.b_okuma_istek_gecerli_i || bus.v_okuma_istek_gecerli_i) begin
        w = kazanan(bus.b_okuma_istek_gecerli_i, bus.v_okuma_istek_gecerli_i);
        yeni_islem(w ? v_adr : b_adr);
        hazir_bekle(w, w ? v_adr : b_adr, sure);
      end
    end
  endtask

  task automatic sifirla();
    rst = 1'b1;
    bus.b_okuma_istek_gecerli_i = 1'b0;
    bus.v_okuma_istek_gecerli_i = 1'b0;
    repeat (2) @(negedge clk);
    kontrol("sifir_mesgul", bus.mesgul_o, 0);
    kontrol("sifir_gecerli", bus.bellek_istek_gecerli_o, 0);
    kontrol("sifir_adres", bus.bellek_istek_adres_o, 0);
    kontrol("sifir_hazir", {bus.b_okuma_istek_hazir_o, bus.v_okuma_istek_hazir_o}, 2'b00);
    kontrol("sifir_b_blok", bus.b_okuma_veri_blok_o, 0);
    kontrol("sifir_v_blok", bus.v_okuma_veri_blok_o, 0);
    rst = 1'b0;
    oncelik_v = 1'b0;
    son_b = '0;
    son_v = '0;
  endtask

  initial begin : ana
    int sure;
    bit [1:0] desen;
    rst = 1'b1;
    tohum = $urandom;
    bus.b_okuma_istek_adres_i   = '0;
    bus.v_okuma_istek_adres_i   = '0;
    bus.b_okuma_istek_gecerli_i = 1'b0;
    bus.v_okuma_istek_gecerli_i = 1'b0;
    sifirla();

    // 1: single B read, fixed contents, latency 6.
    bellek_ozel[32'h1230] = 32'h11;
    bellek_ozel[32'h1234] = 32'h22;
    bellek_ozel[32'h1238] = 32'h33;
    bellek_ozel[32'h123C] = 32'h44;
    calistir(1'b1, 1'b0, 32'h0000_1234, '0, sure);
    kontrol("t1_gecikme", sure, 6);
    kontrol("t1_blok", bus.b_okuma_veri_blok_o, 128'h00000044_00000033_00000022_00000011);

    // 2: ties after reset: B then V, then V then B.
    sifirla();
    calistir(1'b1, 1'b1, 32'h0000_4000, 32'h0000_5010, sure);
    calistir(1'b1, 1'b1, 32'h0000_6020, 32'h0000_7034, sure);

    // 3: memory stalls three cycles on beat 2.
    stall_vurus = 2;
    stall_kalan = 3;
    calistir(1'b1, 1'b0, 32'hABCD_0108, '0, sure);
    kontrol("t3_stall_tuketildi", stall_kalan, 0);
    stall_vurus = -1;

    // 4: responses overlap issues, then pause and arrive bunched.
    bosluk_sonra = 1;
    bosluk_kalan = 3;
    calistir(1'b0, 1'b1, '0, 32'h1357_9BDF, sure);
    kontrol("t4_bosluk_tuketildi", bosluk_kalan, 0);
    bosluk_sonra = -1;

    // 5: reset after two responses; stale response lands in BOSTA and is ignored.
    bus.b_okuma_istek_adres_i   = 32'h0000_2200;
    bus.b_okuma_istek_gecerli_i = 1'b1;
    void'(kazanan(1'b1, 1'b0));
    yeni_islem(32'h0000_2200);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    kontrol("t5_mesgul", bus.mesgul_o, 0);
    kontrol("t5_gecerli", bus.bellek_istek_gecerli_o, 0);
    kontrol("t5_adres", bus.bellek_istek_adres_o, 0);
    kontrol("t5_b_blok", bus.b_okuma_veri_blok_o, 0);
    kontrol("t5_v_blok", bus.v_okuma_veri_blok_o, 0);
    bus.b_okuma_istek_gecerli_i = 1'b0;
    #1 rst = 1'b0;
    oncelik_v = 1'b0;
    son_b = '0;
    son_v = '0;
    for (int i = 0; i < 20 && bekleyen.size() > 0; i++) @(negedge clk);
    kontrol("t5_bekleyen_bos", bekleyen.size(), 0);
    @(negedge clk);
    kontrol("t5_bosta_kalir", {bus.mesgul_o, bus.b_okuma_istek_hazir_o}, 2'b00);
    calistir(1'b1, 1'b0, 32'h0000_3344, '0, sure);
    kontrol("t5_taze_gecikme", sure, 6);

    // 6: B address changes mid-read; latched base must be used.
    bus.b_okuma_istek_adres_i   = 32'h0000_8A64;
    bus.b_okuma_istek_gecerli_i = 1'b1;
    void'(kazanan(1'b1, 1'b0));
    yeni_islem(32'h0000_8A64);
    repeat (3) @(negedge clk);
    bus.b_okuma_istek_adres_i = 32'hFFFF_0000;
    hazir_bekle(1'b0, 32'h0000_8A64, sure);

    // Randomized traffic.
    for (int n = 0; n < 20; n++) begin
      gecikme    = $urandom_range(1, 3);
      hazir_olas = $urandom_range(40, 100);
      yanit_olas = $urandom_range(40, 100);
      desen      = 2'($urandom_range(1, 3));
      calistir(desen[0], desen[1], $urandom, $urandom, sure);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vektor, hata);
    $finish;
  end

endmodule
